// File: rtl/sys_bus_arbiter.sv
// Two-master arbiter for sys_bus: registered one-hot grants, a mux select
// and per-master stall flags, with round-robin ties and a tenure limit.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous reset, active-high
//   master0_request  CPU wants the bus (held high until done)
//   master1_request  secondary master wants the bus (held high until done)
//   grant0 / grant1  registered one-hot ownership
//   bus_sel          registered mux select, 0 = master0 path, 1 = master1
//   hold_flag0/1     stall to each master: request & ~grant
//   bus_busy         grant0 | grant1

module sys_bus_arbiter #(
    parameter int unsigned MAX_TENURE = 16,
    parameter int unsigned CNT_W      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic master0_request,
    input  logic master1_request,
    output logic grant0,
    output logic grant1,
    output logic bus_sel,
    output logic hold_flag0,
    output logic hold_flag1,
    output logic bus_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_e;

    localparam logic             PREEMPT_EN = (MAX_TENURE != 0);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    // Count value on the last contended cycle an owner may keep the bus.
    localparam logic [CNT_W-1:0] TEN_LAST   =
        (MAX_TENURE == 0) ? '0 : CNT_W'(MAX_TENURE - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             sel_q, sel_d;

    logic             tenure_up;
    logic             contend;

    assign tenure_up = PREEMPT_EN && (cnt_q == TEN_LAST);

    // The owner is contended when the other master is waiting.
    assign contend = ((state_q == OWN0) && master1_request) ||
                     ((state_q == OWN1) && master0_request);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        sel_d   = sel_q;

        unique case (state_q)
            IDLE: begin
                if (master0_request && !master1_request) begin
                    state_d = OWN0;
                end else if (master1_request && !master0_request) begin
                    state_d = OWN1;
                end else if (master0_request && master1_request) begin
                    // Tie goes to whoever did not own the bus last.
                    state_d = last_q ? OWN0 : OWN1;
                end
            end
            OWN0: begin
                if (!master0_request) begin
                    state_d = master1_request ? OWN1 : IDLE;
                end else if (master1_request && tenure_up) begin
                    state_d = OWN1;
                end
            end
            OWN1: begin
                if (!master1_request) begin
                    state_d = master0_request ? OWN0 : IDLE;
                end else if (master0_request && tenure_up) begin
                    state_d = OWN0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Fresh tenure on every handover; only contended cycles count.
        if ((state_d != state_q) || (state_d == IDLE)) begin
            cnt_d = '0;
        end else if (contend && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // bus_sel and last owner freeze in IDLE so the muxes stay put.
        if (state_d == OWN0) begin
            last_d = 1'b0;
            sel_d  = 1'b0;
        end else if (state_d == OWN1) begin
            last_d = 1'b1;
            sel_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
        end
    end

    assign grant0     = (state_q == OWN0);
    assign grant1     = (state_q == OWN1);
    assign bus_sel    = sel_q;
    assign bus_busy   = grant0 | grant1;
    assign hold_flag0 = master0_request & ~grant0;
    assign hold_flag1 = master1_request & ~grant1;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Randomized and directed bench for sys_bus_arbiter, two instances
// (MAX_TENURE 4 and 0) checked against a cycle-level owner model.

module tb_sys_bus_arbiter;

    logic       clk;
    logic       rst;
    logic       req0;
    logic       req1;
    logic [1:0] g0;
    logic [1:0] g1;
    logic [1:0] sel;
    logic [1:0] h0;
    logic [1:0] h1;
    logic [1:0] busy;

    int vectors;
    int miscompares;

    // Reference model: owner -1 = nobody, 0/1 = master index.
    int mt[2];
    int own_m[2];
    int cnt_m[2];
    int last_m[2];
    int sel_m[2];

    sys_bus_arbiter #(.MAX_TENURE(4), .CNT_W(8)) u_dut4 (
        .clk             (clk),
        .rst             (rst),
        .master0_request (req0),
        .master1_request (req1),
        .grant0          (g0[0]),
        .grant1          (g1[0]),
        .bus_sel         (sel[0]),
        .hold_flag0      (h0[0]),
        .hold_flag1      (h1[0]),
        .bus_busy        (busy[0])
    );

    sys_bus_arbiter #(.MAX_TENURE(0), .CNT_W(8)) u_dut0 (
        .clk             (clk),
        .rst             (rst),
        .master0_request (req0),
        .master1_request (req1),
        .grant0          (g0[1]),
        .grant1          (g1[1]),
        .bus_sel         (sel[1]),
        .hold_flag0      (h0[1]),
        .hold_flag1      (h1[1]),
        .bus_busy        (busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     tag, $time, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            own_m[i]  = -1;
            cnt_m[i]  = 0;
            last_m[i] = 1;
            sel_m[i]  = 0;
        end
    endfunction

    // One rising edge worth of arbitration with the current requests.
    function automatic void model_step();
        int r[2];
        int nxt;
        int x;
        int y;
        r[0] = int'(req0);
        r[1] = int'(req1);
        for (int i = 0; i < 2; i++) begin
            nxt = own_m[i];
            if (own_m[i] < 0) begin
                if (r[0] != 0 && r[1] != 0) nxt = 1 - last_m[i];
                else if (r[0] != 0)         nxt = 0;
                else if (r[1] != 0)         nxt = 1;
            end else begin
                x = own_m[i];
                y = 1 - x;
                if (r[x] == 0)
                    nxt = (r[y] != 0) ? y : -1;
                else if (r[y] != 0 && mt[i] != 0 && cnt_m[i] == mt[i] - 1)
                    nxt = y;
            end
            if (nxt < 0 || nxt != own_m[i]) cnt_m[i] = 0;
            else if (r[1 - nxt] != 0 && cnt_m[i] < 255) cnt_m[i]++;
            if (nxt >= 0) begin
                last_m[i] = nxt;
                sel_m[i]  = nxt;
            end
            own_m[i] = nxt;
        end
    endfunction

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("grant0[%0d]", i), 32'(g0[i]), 32'(own_m[i] == 0));
            chk($sformatf("grant1[%0d]", i), 32'(g1[i]), 32'(own_m[i] == 1));
            chk($sformatf("bus_sel[%0d]", i), 32'(sel[i]), 32'(sel_m[i]));
            chk($sformatf("bus_busy[%0d]", i), 32'(busy[i]),
                32'(own_m[i] >= 0));
            chk($sformatf("hold0[%0d]", i), 32'(h0[i]),
                32'(req0 && own_m[i] != 0));
            chk($sformatf("hold1[%0d]", i), 32'(h1[i]),
                32'(req1 && own_m[i] != 1));
            chk($sformatf("mutex[%0d]", i), 32'(g0[i] & g1[i]), 32'(0));
        end
    endtask

    task automatic cycle(input logic a, input logic b);
        req0 = a;
        req1 = b;
        #1;
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Asserted between edges: outputs must clear without a clock edge.
    task automatic do_reset(input logic a, input logic b);
        req0 = a;
        req1 = b;
        rst  = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        logic p0;
        logic p1;
        vectors     = 0;
        miscompares = 0;
        mt[0] = 4;
        mt[1] = 0;
        req0 = 1'b0;
        req1 = 1'b0;
        rst  = 1'b0;
        #2;

        // Single master0 burst, then idle with bus_sel held.
        do_reset(1'b0, 1'b0);
        repeat (3) cycle(1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b0);

        // First tie after reset goes to master0, then direct handover.
        do_reset(1'b0, 1'b0);
        repeat (2) cycle(1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b1);
        repeat (2) cycle(1'b0, 1'b0);

        // Round robin with repeated one-cycle pulses.
        repeat (6) begin
            cycle(1'b1, 1'b1);
            cycle(1'b0, 1'b0);
        end

        // Tenure preemption: master1 joins at cycle 5.
        do_reset(1'b0, 1'b0);
        repeat (5) cycle(1'b1, 1'b0);
        repeat (12) cycle(1'b1, 1'b1);
        chk("preempt_g1", 32'(g1[0]), 32'(1));
        chk("no_preempt_g0", 32'(g0[1]), 32'(1));
        repeat (4) cycle(1'b0, 1'b1);
        repeat (2) cycle(1'b0, 1'b0);

        // Randomized requests with some persistence.
        do_reset(1'b0, 1'b0);
        p0 = 1'b0;
        p1 = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 3) == 0) p0 = ~p0;
            if ($urandom_range(0, 3) == 0) p1 = ~p1;
            cycle(p0, p1);
        end

        // Reset in the middle of a master1 tenure.
        repeat (2) cycle(1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b1);
        chk("own1_before_rst", 32'(g1[0]), 32'(1));
        do_reset(1'b1, 1'b1);
        chk("m0_first_after_rst", 32'(g0[0]), 32'(1));
        repeat (6) cycle(1'b1, 1'b1);
        repeat (2) cycle(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sys_bus_arbiter.md
Name: sys_bus_arbiter

Overview:
- Two-master arbiter for sys_bus. It decides which master (master0 = CPU, master1 = secondary master such as DMA or debug) owns the shared slave path.
- Produces registered one-hot grants, a mux select for the bus master-side muxes, and per-master hold_flag stall signals.
- Uses round-robin tie-breaking and a tenure limit so a streaming master cannot starve the other.
- Sits inside sys_bus, between the master request inputs and the address/data/we muxes.

Parameters:
- MAX_TENURE, 16, max consecutive owned cycles while the other master is waiting; 0 disables preemption.
- CNT_W, 8, tenure counter width; MAX_TENURE must be <= 2^CNT_W - 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- master0_request  input  1  master0 wants the bus this cycle; held high until done.
- master1_request  input  1  master1 wants the bus this cycle; held high until done.
- grant0  output  1  master0 owns the bus (registered).
- grant1  output  1  master1 owns the bus (registered).
- bus_sel  output  1  mux select: 0 = master0 path, 1 = master1 path (registered).
- hold_flag0  output  1  stall to master0: master0_request & ~grant0.
- hold_flag1  output  1  stall to master1: master1_request & ~grant1.
- bus_busy  output  1  grant0 | grant1.

Behaviour:
- One clock, clk. rst is asynchronous, active-high.
- Reset values:
  - state = IDLE; grant0 = grant1 = 0; bus_sel = 0; bus_busy = 0.
  - tenure counter cnt = 0; internal last_owner = 1, so master0 wins the first tie.
- hold_flag0/1 are combinational from request and registered grant. After reset they equal the raw requests.
- States: IDLE, OWN0, OWN1. grant0 = (state == OWN0), grant1 = (state == OWN1).
- IDLE:
  - Only master0 requests -> OWN0.
  - Only master1 requests -> OWN1.
  - Both request -> the master != last_owner.
  - Neither requests -> stay in IDLE.
- OWNx, own request dropped:
  - Other master requesting -> OWNy directly, no idle gap cycle.
  - Otherwise -> IDLE.
- OWNx, own request still high:
  - Other master requesting, MAX_TENURE != 0 and cnt == MAX_TENURE-1 -> preempt to OWNy.
  - Otherwise stay in OWNx.
- Latency: a request from IDLE is granted on the next rising edge, so hold_flag is high for exactly 1 cycle. A handover in either direction takes effect on the edge after the release or preempt condition.
- Tenure counter:
  - Cleared to 0 on every entry into an OWN state and in IDLE.
  - Increments by 1 per cycle in OWNx only while the other master is requesting; holds otherwise.
  - Saturates at 2^CNT_W - 1.
  - Effect: MAX_TENURE counts contended cycles, so an uncontended owner keeps the bus indefinitely.
- last_owner updates to x on every entry into OWNx; it holds in IDLE.
- bus_sel updates with the grant: 0 on entry to OWN0, 1 on entry to OWN1. In IDLE it keeps its last value so bus muxes do not toggle.
- A preempted master sees hold_flag rise in the first cycle after losing the grant. Its request stays pending and is re-granted by the normal rules.
- Grants are mutually exclusive in every cycle; the bench asserts grant0 & grant1 == 0 always.
- Reset mid-tenure: grants, bus_sel and cnt clear immediately and asynchronously without waiting for clk. After rst deasserts, arbitration restarts as from power-up (master0 wins ties).
- X on a request is not resolved; the bench drives 0/1 only.

Test Plan:
- Single master0: master0_request=1 at cycle 0 for 3 cycles -> hold_flag0=1 in cycle 0 only; grant0=1 in cycles 1-3; returns to IDLE in cycle 4 with bus_sel=0 held.
- Simultaneous first requests after reset: both requests high at cycle 0, master0 drops at cycle 2 -> grant0 in cycles 1-2; grant1=1 from cycle 3 with no idle gap; bus_sel=1 from cycle 3.
- Round robin: from IDLE with last_owner=1, both pulse 1-cycle requests repeatedly -> grants alternate 0,1,0,1; hold_flag high only for the waiting master.
- Tenure preemption, MAX_TENURE=4: master0 holds request continuously; master1 requests from cycle 5 -> grant0 stays through cycle 8, grant1=1 at cycle 9, hold_flag0=1 from cycle 9.
- MAX_TENURE=0: same stimulus -> grant0 stays high indefinitely while master0_request=1; grant1 only after master0 releases.
- Reset mid-grant: assert rst during OWN1 between edges -> grant1, bus_sel, bus_busy go to 0 immediately. After release with both requesting, master0 is granted first.
